axi_lite_adc_regs: RTL and testbench
====================================

Name: axi_lite_adc_regs

Overview:
Parametrised AXI4-Lite control/status register block for the multi-channel AD9643 capture path. It provides the following per channel:
- data enable
- synchronised live overrange status
- sticky write-1-to-clear overrange flags
- saturating overrange event counters

It also provides a self-timed IDELAY reset pulse and SLVERR on unmapped addresses. It sits between the PS AXI interconnect and the ADC data/IDELAY logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 6, AXI byte address width; must satisfy 0x10+4*NUM_CH <= 2^C_S_AXI_ADDR_WIDTH.
NUM_CH, 2, ADC channel count, 1..16.
CNT_W, 16, overrange counter width, 1..32.
RST_PULSE, 4, delay_rst pulse length in clocks, >=1.

Ports:
s_axi_aclk  in  1  clock for all logic.
s_axi_areset  in  1  asynchronous, active-high reset.
adc_or  in  NUM_CH  per-channel overrange, asynchronous to s_axi_aclk.
data_en  out  NUM_CH  per-channel data enable, CTRL[NUM_CH-1:0].
delay_rst  out  1  IDELAY reset pulse.
s_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite slave; prot inputs are ignored.

Behaviour:
- Reset: all outputs 0 (awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, data_en, delay_rst); all registers, sync flops and counters 0.
- adc_or path: 2-FF synchroniser per channel, then a rising-edge detect on the synchronised value.
- Register map (word-aligned; addr[1:0] ignored):
  - 0x00 CTRL, RW: [NUM_CH-1:0] data_en; [16] delay_rst trigger, reads 1 while the pulse is active; other bits read 0.
  - 0x04 STATUS, RO: [NUM_CH-1:0] synchronised live adc_or. Writes are ignored and return OKAY.
  - 0x08 OR_STICKY, W1C: bit ch sets on a rising edge of channel ch.
  - 0x0C IRQ_MASK: see Optional Feature.
  - 0x10+4*ch OR_CNT[ch]: saturating rising-edge count (saturates at 2^CNT_W-1, no wrap). Any write with a nonzero wstrb clears it to 0.
  - Any other address: reads return 0 with RESP=SLVERR (2'b10); writes have no effect and return SLVERR.
- Write channel:
  - AW and W are accepted independently. awready/wready pulse for 1 cycle on valid when the respective holding slot is empty and bvalid=0.
  - The register update occurs in the cycle after both slots are full.
  - bvalid asserts in that same cycle and holds until bready; both slots free when bvalid&bready.
  - wstrb byte lanes apply to CTRL, OR_STICKY and IRQ_MASK.
- Read channel:
  - arready pulses 1 cycle when arvalid and rvalid=0.
  - rdata/rresp register on the next edge with rvalid=1; held stable until rready.
  - Read latency is 2 cycles from arvalid to rvalid with arvalid held.
- Simultaneous events:
  - A set on OR_STICKY wins over a W1C clear in the same cycle.
  - A counter increment in the same cycle as a write-clear yields 1.
  - Simultaneous read and write to the same register: the read returns the pre-write value.
- delay_rst:
  - A CTRL write with wstrb[2]=1 and wdata[16]=1 loads a down-counter with RST_PULSE.
  - delay_rst is high exactly RST_PULSE cycles, starting the cycle after the update.
  - Re-trigger during the pulse restarts the full count.
- Reset mid-transaction: all handshakes abort immediately; the master must reissue.

Optional Feature:
Macro AXI_LITE_ADC_REGS_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, reset 0), registered: irq = |(OR_STICKY & IRQ_MASK).
  - IRQ_MASK at 0x0C is RW over [NUM_CH-1:0], reset 0.
- Undefined:
  - No irq port.
  - 0x0C behaves as an unmapped address (SLVERR, reads 0).

Test Plan:
1. After reset, write 0x00=0x00000003 with wstrb=0xF -> data_en=2'b11, bresp=OKAY; read 0x00 -> 0x00000003.
2. Write 0x00=0x00010001 -> delay_rst high exactly 4 cycles; a re-trigger at cycle 2 extends it to cycle 6; a read during the pulse returns bit16=1.
3. Drive 3 rising edges on adc_or[1] -> OR_STICKY=0x2, OR_CNT[1] (0x14)=3, STATUS follows the live level after 2 cycles; write 0x08=0x2 -> OR_STICKY=0.
4. Set CNT_W=4 and drive 20 edges -> OR_CNT[0]=15 (saturated); any write to 0x10 -> 0.
5. Read 0x3C with NUM_CH=2 -> rresp=SLVERR, rdata=0; write 0x3C -> bresp=SLVERR and no register changes. Present W 3 cycles before AW -> a single write completes with one bvalid.
6. With IRQ_EN defined: IRQ_MASK=0x1 and an edge on ch0 -> irq=1 the cycle after OR_STICKY sets; W1C of bit0 -> irq=0. An edge on ch0 coincident with the W1C -> sticky bit stays 1.

Source files
------------

// File: rtl/axi_lite_adc_regs.sv
// rtl/axi_lite_adc_regs.sv - AXI4-Lite control/status registers for the AD9643 capture path (optional irq: AXI_LITE_ADC_REGS_IRQ_EN)
module axi_lite_adc_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 2,
  parameter int CNT_W              = 16,
  parameter int RST_PULSE          = 4
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [NUM_CH-1:0]               adc_or,
  output logic [NUM_CH-1:0]               data_en,
  output logic                            delay_rst,
`ifdef AXI_LITE_ADC_REGS_IRQ_EN
  output logic                            irq,
`endif
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int IW  = AW - 2;
  localparam int RCW = $clog2(RST_PULSE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // write holding slots
  logic              aw_full;
  logic              w_full;
  logic [IW-1:0]     aw_idx;
  logic [DW-1:0]     w_data;
  logic [DW/8-1:0]   w_strb;
  logic [DW-1:0]     wmask;

  // write decode
  logic              wr_fire;
  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_sticky;
  logic              wr_mask_sel;
  logic [NUM_CH-1:0] wr_cnt_sel;
  logic [NUM_CH-1:0] wr_cnt_clr;
  logic              wr_hit;
  logic              rst_trig;

  // read decode
  logic [IW-1:0]     ar_idx;
  logic [DW-1:0]     rd_data;
  logic [1:0]        rd_resp;

  // overrange path and registers
  logic [NUM_CH-1:0] or_s1;
  logic [NUM_CH-1:0] or_s2;
  logic [NUM_CH-1:0] or_d;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] or_sticky;
  logic [NUM_CH-1:0] sticky_clr;
  logic [CNT_W-1:0]  or_cnt [NUM_CH];
  logic [RCW-1:0]    rst_cnt;
  logic [RCW-1:0]    rst_cnt_nxt;
`ifdef AXI_LITE_ADC_REGS_IRQ_EN
  logic [NUM_CH-1:0] irq_mask;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                           s_axi_araddr[1:0], w_data, wmask};

  assign ar_idx  = s_axi_araddr[AW-1:2];
  assign wr_fire = aw_full & w_full & ~s_axi_bvalid;
  assign rise    = or_s2 & ~or_d;

  // Expand byte strobes into a bit mask for the held write data
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DW/8; b++) begin
      wmask[b*8 +: 8] = {8{w_strb[b]}};
    end
  end

  // Decode the held write address; only meaningful while wr_fire is high
  always_comb begin
    wr_ctrl     = wr_fire && (aw_idx == IW'(0));
    wr_status   = wr_fire && (aw_idx == IW'(1));
    wr_sticky   = wr_fire && (aw_idx == IW'(2));
`ifdef AXI_LITE_ADC_REGS_IRQ_EN
    wr_mask_sel = wr_fire && (aw_idx == IW'(3));
`else
    wr_mask_sel = 1'b0;
`endif
    wr_cnt_sel  = '0;
    wr_cnt_clr  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_fire && (aw_idx == IW'(4 + c))) begin
        wr_cnt_sel[c] = 1'b1;
        wr_cnt_clr[c] = |w_strb;
      end
    end
    wr_hit     = wr_ctrl | wr_status | wr_sticky | wr_mask_sel | (|wr_cnt_sel);
    rst_trig   = wr_ctrl && w_strb[2] && w_data[16];
    sticky_clr = wr_sticky ? (w_data[NUM_CH-1:0] & wmask[NUM_CH-1:0]) : '0;
  end

  // Read mux, sampled into rdata on the AR handshake so reads see pre-write values
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ar_idx == IW'(0)) begin
      rd_data[NUM_CH-1:0] = data_en;
      rd_data[16]         = delay_rst;
    end else if (ar_idx == IW'(1)) begin
      rd_data[NUM_CH-1:0] = or_s2;
    end else if (ar_idx == IW'(2)) begin
      rd_data[NUM_CH-1:0] = or_sticky;
`ifdef AXI_LITE_ADC_REGS_IRQ_EN
    end else if (ar_idx == IW'(3)) begin
      rd_data[NUM_CH-1:0] = irq_mask;
`endif
    end else begin
      rd_resp = RESP_SLVERR;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ar_idx == IW'(4 + c)) begin
          rd_resp            = RESP_OKAY;
          rd_data[CNT_W-1:0] = or_cnt[c];
        end
      end
    end
  end

  // Down-counter behind delay_rst; a re-trigger reloads the full length
  always_comb begin
    rst_cnt_nxt = rst_cnt;
    if (rst_trig) begin
      rst_cnt_nxt = RCW'(RST_PULSE);
    end else if (rst_cnt != '0) begin
      rst_cnt_nxt = rst_cnt - RCW'(1);
    end
  end

  // AW slot: one-cycle awready pulse, slot held until the B handshake
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      s_axi_awready <= 1'b0;
      aw_full       <= 1'b0;
      aw_idx        <= '0;
    end else begin
      s_axi_awready <= 1'b0;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axi_awaddr[AW-1:2];
      end else if (s_axi_awvalid && !s_axi_awready && !aw_full && !s_axi_bvalid) begin
        s_axi_awready <= 1'b1;
      end
      if (s_axi_bvalid && s_axi_bready) begin
        aw_full <= 1'b0;
      end
    end
  end

  // W slot: accepted independently of AW, same release rule
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      s_axi_wready <= 1'b0;
      w_full       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
    end else begin
      s_axi_wready <= 1'b0;
      if (s_axi_wvalid && s_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end else if (s_axi_wvalid && !s_axi_wready && !w_full && !s_axi_bvalid) begin
        s_axi_wready <= 1'b1;
      end
      if (s_axi_bvalid && s_axi_bready) begin
        w_full <= 1'b0;
      end
    end
  end

  // B channel: response raised in the register-update cycle, held until bready
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (wr_fire) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_bvalid && s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  // AR/R channel: arready pulse, then data registered with rvalid until rready
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= 1'b0;
      if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_arvalid && !s_axi_arready && !s_axi_rvalid) begin
        s_axi_arready <= 1'b1;
      end
    end
  end

  // Two-flop synchroniser plus delayed copy for rising-edge detection
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      or_s1 <= '0;
      or_s2 <= '0;
      or_d  <= '0;
    end else begin
      or_s1 <= adc_or;
      or_s2 <= or_s1;
      or_d  <= or_s2;
    end
  end

  // CTRL enables, delay_rst pulse and sticky flags (a new edge beats a W1C)
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      data_en   <= '0;
      rst_cnt   <= '0;
      delay_rst <= 1'b0;
      or_sticky <= '0;
    end else begin
      if (wr_ctrl) begin
        data_en <= (data_en & ~wmask[NUM_CH-1:0]) | (w_data[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
      end
      rst_cnt   <= rst_cnt_nxt;
      delay_rst <= (rst_cnt_nxt != '0);
      or_sticky <= (or_sticky & ~sticky_clr) | rise;
    end
  end

  // Saturating edge counters; an edge coinciding with a clear counts as one
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        or_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_cnt_clr[c]) begin
          or_cnt[c] <= rise[c] ? CNT_W'(1) : '0;
        end else if (rise[c] && (or_cnt[c] != CNT_MAX)) begin
          or_cnt[c] <= or_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

`ifdef AXI_LITE_ADC_REGS_IRQ_EN
  // Interrupt mask and registered interrupt output
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_mask_sel) begin
        irq_mask <= (irq_mask & ~wmask[NUM_CH-1:0]) | (w_data[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
      end
      irq <= |(or_sticky & irq_mask);
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_adc_regs.sv
// tb/tb_axi_lite_adc_regs.sv - scoreboard testbench for axi_lite_adc_regs
module tb_axi_lite_adc_regs;
  localparam int NCH  = 2;
  localparam int CW   = 4;
  localparam int RP   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] adc_or;
  logic [NCH-1:0] data_en;
  logic delay_rst;
`ifdef AXI_LITE_ADC_REGS_IRQ_EN
  logic irq;
`endif
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_adc_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_CH(NCH),
                      .CNT_W(CW), .RST_PULSE(RP)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .adc_or(adc_or), .data_en(data_en),
    .delay_rst(delay_rst),
`ifdef AXI_LITE_ADC_REGS_IRQ_EN
    .irq(irq),
`endif
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_araddr(araddr),
    .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready));

  typedef struct {logic [1:0] resp; logic [31:0] data;} rexp_t;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  int         upd_q[$];
  bit         bp_en = 1'b0;
  int         cyc = 0;
  int         run = 0;
  int         last_pulse = 0;

  // reference model state
  logic [NCH-1:0] m_en, m_sticky, m_mask;
  int             m_cnt[NCH];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic void mdl_reset();
    m_en = '0; m_sticky = '0; m_mask = '0;
    for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
  endfunction

  function automatic void mdl_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int w;
    w = int'(a) / 4;
    d = 32'h0;
    r = 2'b00;
    if (w == 0)      d = 32'(m_en);
    else if (w == 1) d = 32'(adc_or);
    else if (w == 2) d = 32'(m_sticky);
`ifdef AXI_LITE_ADC_REGS_IRQ_EN
    else if (w == 3) d = 32'(m_mask);
`endif
    else if (w >= 4 && w < 4 + NCH) d = 32'(m_cnt[w-4]);
    else r = 2'b10;
  endfunction

  function automatic void mdl_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                                    output logic [1:0] r);
    int w;
    logic [31:0] m;
    w = int'(a) / 4;
    r = 2'b00;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
    if (w == 0)      m_en = (m_en & ~m[NCH-1:0]) | (d[NCH-1:0] & m[NCH-1:0]);
    else if (w == 1) r = 2'b00;
    else if (w == 2) m_sticky = m_sticky & ~(d[NCH-1:0] & m[NCH-1:0]);
`ifdef AXI_LITE_ADC_REGS_IRQ_EN
    else if (w == 3) m_mask = (m_mask & ~m[NCH-1:0]) | (d[NCH-1:0] & m[NCH-1:0]);
`endif
    else if (w >= 4 && w < 4 + NCH) begin
      if (s != 4'h0) m_cnt[w-4] = 0;
    end else r = 2'b10;
  endfunction

  // Scoreboard monitor: pops an expectation on every B and R handshake
  initial forever begin
    rexp_t e;
    logic [1:0] eb;
    @(negedge clk);
    if (!rst) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected actual bresp=%0d required no response", bresp);
        end else begin
          eb = exp_b.pop_front();
          chk("bresp", 32'(bresp), 32'(eb));
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected actual rdata=%h required no response", rdata);
        end else begin
          e = exp_r.pop_front();
          chk("rresp", 32'(rresp), 32'(e.resp));
          chk("rdata", rdata, e.data);
        end
      end
    end
  end

  // Random response backpressure when enabled
  initial forever begin
    @(posedge clk); #1;
    bready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    rready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Cycle counter, delay_rst pulse length and write-update cycle recorder
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    logic bv_prev;
    bv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (delay_rst) run++;
      else if (run > 0) begin last_pulse = run; run = 0; end
      if (bvalid && !bv_prev) upd_q.push_back(cyc);
      bv_prev = bvalid;
    end
  end

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    bit aw_left, w_left, aw_hs, w_hs, done;
    int t;
    aw_left = 1; w_left = 1; t = 0;
    awaddr = a; wdata = d; wstrb = s;
    while ((aw_left || w_left) && t < 40) begin
      awvalid = aw_left && (t >= lead);
      wvalid  = w_left;
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) aw_left = 0;
      if (w_hs) w_left = 0;
      t++;
    end
    awvalid = 0; wvalid = 0;
    if (aw_left || w_left) begin
      checks++; errors++;
      $display("FAIL aw_w_timeout actual=no handshake required=handshake addr=%h", a);
    end
    done = 0; t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      done = bvalid && bready;
      @(posedge clk); #1;
      t++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL b_timeout actual=no bvalid required=bvalid addr=%h", a);
    end
  endtask

  task automatic axi_read(input logic [5:0] a);
    bit hs, done;
    int t;
    hs = 0; t = 0;
    araddr = a;
    while (!hs && t < 40) begin
      arvalid = 1;
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      t++;
    end
    arvalid = 0;
    done = 0; t = 0;
    while (hs && !done && t < 40) begin
      @(negedge clk);
      done = rvalid && rready;
      @(posedge clk); #1;
      t++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL r_timeout actual=no rvalid required=rvalid addr=%h", a);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    logic [1:0] r;
    mdl_write(a, d, s, r);
    exp_b.push_back(r);
    axi_write(a, d, s, lead);
  endtask

  task automatic push_read(input logic [5:0] a);
    rexp_t e;
    mdl_read(a, e.data, e.resp);
    exp_r.push_back(e);
  endtask

  task automatic do_read(input logic [5:0] a);
    push_read(a);
    axi_read(a);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ch(input int c);
    adc_or[c] = 1'b1;
    if (m_cnt[c] < CMAX) m_cnt[c]++;
    m_sticky[c] = 1'b1;
    wait_cyc(4);
    adc_or[c] = 1'b0;
    wait_cyc(4);
  endtask

  initial begin
    logic [5:0] tbl [8];
    logic [5:0] a;
    logic [31:0] d;
    rexp_t e;
    int t1, t2, gap;
    tbl = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h3C};
    rst = 1; adc_or = '0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; wdata = '0; wstrb = '0;
    bready = 1; rready = 1;
    mdl_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_handshakes", 32'({awready, wready, arready, bvalid, rvalid}), 32'h0);
    chk("rst_resp", 32'({bresp, rresp}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_outputs", 32'({data_en, delay_rst}), 32'h0);
    @(posedge clk); #1;
    rst = 0;
    wait_cyc(2);

    // enables
    do_write(6'h00, 32'h3, 4'hF, 0);
    chk("data_en_set", 32'(data_en), 32'(m_en));
    do_read(6'h00);

    // single delay_rst pulse and read of the active trigger bit
    do_write(6'h00, 32'h0001_0001, 4'hF, 0);
    e.resp = 2'b00; e.data = 32'h0001_0001;
    exp_r.push_back(e);
    axi_read(6'h00);
    wait_cyc(12);
    chk("delay_rst_len", 32'(last_pulse), 32'(RP));
    do_read(6'h00);

    // re-trigger while the pulse is running
    upd_q.delete();
    do_write(6'h00, 32'h0001_0001, 4'hF, 0);
    do_write(6'h00, 32'h0001_0001, 4'hF, 0);
    wait_cyc(16);
    if (upd_q.size() >= 2) begin
      t1 = upd_q[0]; t2 = upd_q[1]; gap = t2 - t1;
      chk("delay_rst_retrig_len", 32'(last_pulse), 32'((gap <= RP) ? gap + RP : RP));
    end else begin
      checks++; errors++;
      $display("FAIL retrig_updates actual=%0d required=2", upd_q.size());
    end

    // edges on channel 1, live status, W1C
    for (int i = 0; i < 3; i++) pulse_ch(1);
    do_read(6'h08);
    do_read(6'h14);
    adc_or[1] = 1'b1; m_cnt[1]++; m_sticky[1] = 1'b1;
    wait_cyc(3);
    do_read(6'h04);
    adc_or[1] = 1'b0;
    wait_cyc(3);
    do_read(6'h04);
    do_write(6'h08, 32'h2, 4'hF, 0);
    do_read(6'h08);

    // saturation and clear
    for (int i = 0; i < 20; i++) pulse_ch(0);
    do_read(6'h10);
    do_write(6'h10, $urandom, 4'h1, 0);
    do_read(6'h10);
    do_write(6'h14, 32'h0, 4'h0, 0);
    do_read(6'h14);

    // unmapped, read-only and W-before-AW
    do_read(6'h3C);
    do_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 0);
    do_read(6'h00);
    do_write(6'h04, 32'hFFFF_FFFF, 4'hF, 0);
    do_write(6'h00, 32'h2, 4'hF, 3);
    chk("data_en_w_first", 32'(data_en), 32'(m_en));
`ifndef AXI_LITE_ADC_REGS_IRQ_EN
    do_read(6'h0C);
    do_write(6'h0C, 32'h1, 4'hF, 0);
`endif

    // read and write of the same register together: read sees the old value
    push_read(6'h00);
    fork
      axi_read(6'h00);
      do_write(6'h00, 32'h1, 4'hF, 0);
    join
    do_read(6'h00);

    // edge coincident with a counter clear, then with a sticky W1C
    fork
      adc_or[0] = 1'b1;
      do_write(6'h10, 32'h0, 4'hF, 0);
    join
    m_cnt[0] = 1; m_sticky[0] = 1'b1;
    adc_or[0] = 1'b0;
    wait_cyc(4);
    do_read(6'h10);
    fork
      adc_or[0] = 1'b1;
      do_write(6'h08, 32'h1, 4'hF, 0);
    join
    m_sticky[0] = 1'b1; m_cnt[0]++;
    adc_or[0] = 1'b0;
    wait_cyc(4);
    do_read(6'h08);
    do_read(6'h10);

`ifdef AXI_LITE_ADC_REGS_IRQ_EN
    do_write(6'h08, 32'h3, 4'hF, 0);
    do_write(6'h0C, 32'h1, 4'hF, 0);
    do_read(6'h0C);
    wait_cyc(2);
    chk("irq_idle", 32'(irq), 32'h0);
    adc_or[0] = 1'b1; m_cnt[0]++; m_sticky[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'h1);
    @(posedge clk); #1;
    adc_or[0] = 1'b0;
    wait_cyc(4);
    do_write(6'h08, 32'h1, 4'hF, 0);
    wait_cyc(2);
    chk("irq_clear", 32'(irq), 32'h0);
`endif

    // randomized traffic against the model
    bp_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      a = tbl[$urandom_range(0, 7)] | 6'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin
          d = $urandom;
          if (a[5:2] == 4'h0) d[16] = 1'b0;
          do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
          chk("data_en_rand", 32'(data_en), 32'(m_en));
        end
        1, 2: do_read(a);
        default: pulse_ch($urandom_range(0, NCH - 1));
      endcase
    end
    bp_en = 1'b0;
    wait_cyc(4);

    // reset in the middle of a write
    awaddr = 6'h00; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    wait_cyc(1);
    rst = 1;
    #1;
    chk("rst_mid_hs", 32'({awready, wready, bvalid, rvalid, arready}), 32'h0);
    chk("rst_mid_out", 32'({data_en, delay_rst}), 32'h0);
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    rst = 0;
    mdl_reset();
    wait_cyc(2);
    do_read(6'h00);
    do_read(6'h10);

    wait_cyc(4);
    chk("queues_empty", 32'(exp_b.size() + exp_r.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
